csi_param_parser: RTL and testbench
===================================

Name: csi_param_parser

Overview:
- Byte-stream parser for ANSI/VT100 control sequences, with numeric parameters, feeding the terminal command layer.
- Recognises ESC '[' [ '?' ] {digits | ';'} final-byte.
- Accumulates up to NPARAM decimal parameters with saturation and emits one registered command pulse carrying the final byte and parameter vector.
- Non-escape bytes pass through as text characters; malformed or stalled sequences raise a one-cycle error and resynchronise.

Parameters:
- NPARAM, 2, maximum number of stored numeric parameters (>=1).
- PW, 8, width of each parameter value; saturates at 2^PW-1.
- TIMEOUT, 1024, idle cycles allowed inside a sequence before abort (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data valid this cycle; one byte accepted per valid cycle, no backpressure.
- in_data  in  8  input byte.
- char_valid  out  1  one-cycle pulse: pass-through character.
- char_data  out  8  pass-through byte; held until next char_valid.
- cmd_valid  out  1  one-cycle pulse: complete CSI sequence.
- cmd_final  out  8  final byte (0x40..0x7E).
- cmd_private  out  1  '?' prefix present.
- cmd_nparam  out  $clog2(NPARAM+1)  number of parameter fields, capped at NPARAM.
- cmd_params  out  NPARAM*PW  parameter i in bits [i*PW +: PW]; missing or empty fields are 0.
- cmd_overflow  out  1  more than NPARAM fields were received; extras were discarded.
- seq_error  out  1  one-cycle pulse: malformed or timed-out sequence.
- busy  out  1  high while the FSM is in ESC or CSI.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs, accumulators, index and timeout counter are cleared to 0.
  - rst overrides in_valid in the same cycle.
  - Reset mid-sequence discards the partial sequence and produces no pulse.
- All outputs are registered. Latency is 1 cycle from the accepting edge of a byte to its char_valid, cmd_valid or seq_error pulse. cmd_* and char_data hold their values between pulses.
- FSM states: IDLE, ESC, CSI. Transitions happen only on cycles with in_valid=1, except timeout.
- IDLE:
  - 0x1B -> ESC.
  - Any other byte -> char_valid pulse, char_data = byte, remain IDLE.
- ESC:
  - 0x5B -> CSI. Clear params, index, private, field_seen and overflow.
  - 0x1B -> remain ESC, no error.
  - Any other byte -> seq_error, IDLE, byte dropped.
- CSI:
  - '0'..'9': acc[idx] = min(acc[idx]*10 + digit, 2^PW-1). Compute at PW+4 bits, then saturate. Sets field_seen. Digits are ignored once overflow is set.
  - ';' (0x3B): sets field_seen. If idx < NPARAM-1, idx++; otherwise set overflow.
  - '?' (0x3F): legal only as the first byte after '['; sets private. Anywhere else -> seq_error, IDLE.
  - 0x40..0x7E: final byte.
    - cmd_valid pulse; cmd_final = byte; cmd_params = acc.
    - cmd_nparam = field_seen ? min(semicolon count + 1, NPARAM) : 0.
    - cmd_private and cmd_overflow are latched.
    - -> IDLE.
  - 0x1B -> seq_error, -> ESC (new sequence starts).
  - 0x18 or 0x1A (CAN/SUB) -> IDLE silently, no error.
  - Any other byte (controls, 0x20..0x2F intermediates, ':' '<' '=' '>') -> seq_error, IDLE.
- Timeout:
  - Counter resets on every accepted byte and increments each cycle in ESC/CSI while in_valid=0.
  - When the counter reaches TIMEOUT: seq_error, IDLE, counter cleared. No pulse is emitted while in IDLE.
- At most one of char_valid, cmd_valid, seq_error is asserted in any cycle.
- Back-to-back bytes on every cycle are fully supported, including a final byte immediately followed by 0x1B.

Test Plan:
- Defaults, bytes 1B 5B 31 32 3B 33 34 48 on consecutive cycles -> one cmd_valid; cmd_final=0x48, nparam=2, params={34,12} (p0=12, p1=34), private=0, overflow=0. No char_valid and no seq_error.
- 1B 5B 43, then 'a' (0x61) -> cmd_valid with final=0x43, nparam=0, params=0. Next cycle char_valid with char_data=0x61.
- PW=8, bytes 1B 5B 39 39 39 6D -> p0=255 (saturated), nparam=1, final=0x6D. Then 1B 5B 3B 35 48 -> p0=0, p1=5, nparam=2.
- NPARAM=2, bytes 1B 5B 31 3B 32 3B 33 48 -> p0=1, p1=2, nparam=2, overflow=1. Then 1B 5B 3F 32 35 68 -> private=1, p0=25, final=0x68, overflow=0.
- Errors: 1B 78 -> seq_error and 0x78 dropped. 1B 5B 31 3F -> seq_error. 1B 5B 31 1B 5B 41 -> seq_error on the second 0x1B, then cmd_valid with final=0x41, nparam=0.
- TIMEOUT=16:
  - 1B 5B 32 then 16 idle cycles -> seq_error exactly once, busy drops. A following 0x41 appears as char_valid.
  - rst asserted after 1B 5B 35 -> no pulses, all outputs 0; a following 0x48 appears as char_valid.

Source files
------------

// File: rtl/csi_param_parser_if.sv
// Byte-stream and decoded-output bundle for the CSI control-sequence parser.
interface csi_param_parser_if #(
  parameter int unsigned NPARAM = 2,
  parameter int unsigned PW     = 8
) ();
  localparam int unsigned NW = $clog2(NPARAM + 1);

  logic                 in_valid;
  logic [7:0]           in_data;
  logic                 char_valid;
  logic [7:0]           char_data;
  logic                 cmd_valid;
  logic [7:0]           cmd_final;
  logic                 cmd_private;
  logic [NW-1:0]        cmd_nparam;
  logic [NPARAM*PW-1:0] cmd_params;
  logic                 cmd_overflow;
  logic                 seq_error;
  logic                 busy;

  modport master (
    output in_valid, in_data,
    input  char_valid, char_data, cmd_valid, cmd_final, cmd_private,
           cmd_nparam, cmd_params, cmd_overflow, seq_error, busy
  );

  modport slave (
    input  in_valid, in_data,
    output char_valid, char_data, cmd_valid, cmd_final, cmd_private,
           cmd_nparam, cmd_params, cmd_overflow, seq_error, busy
  );
endinterface

// File: rtl/csi_param_parser.sv
// ANSI/VT100 CSI parser: ESC '[' ['?'] {digits|';'} final, with saturating
// decimal parameters, text pass-through and timeout/malformed-sequence errors.
module csi_param_parser #(
  parameter int unsigned NPARAM  = 2,
  parameter int unsigned PW      = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  csi_param_parser_if.slave bus
);
  localparam int unsigned NW = $clog2(NPARAM + 1);
  localparam int unsigned IW = (NPARAM > 1) ? $clog2(NPARAM) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned AW = PW + 4;
  localparam logic [IW-1:0] IDX_LAST = IW'(NPARAM - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [AW-1:0] TEN      = AW'(10);
  localparam logic [AW-1:0] SAT      = {4'b0000, {PW{1'b1}}};

  typedef enum logic [1:0] {IDLE, ESC, CSI} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    acc [NPARAM];
  logic [PW-1:0]    acc_n [NPARAM];
  logic [IW-1:0]    idx, idx_n;
  logic             priv, priv_n;
  logic             field_seen, field_seen_n;
  logic             ovf, ovf_n;
  logic             first, first_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [AW-1:0]    prod;
  logic [7:0]       d;

  logic                 char_valid_n, cmd_valid_n, seq_error_n;
  logic [7:0]           char_data_n, cmd_final_n;
  logic                 cmd_private_n, cmd_overflow_n;
  logic [NW-1:0]        cmd_nparam_n;
  logic [NPARAM*PW-1:0] cmd_params_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      for (int unsigned i = 0; i < NPARAM; i++) acc[i] <= '0;
      idx        <= '0;
      priv       <= 1'b0;
      field_seen <= 1'b0;
      ovf        <= 1'b0;
      first      <= 1'b0;
      tcnt       <= '0;
      bus.char_valid   <= 1'b0;
      bus.char_data    <= '0;
      bus.cmd_valid    <= 1'b0;
      bus.cmd_final    <= '0;
      bus.cmd_private  <= 1'b0;
      bus.cmd_nparam   <= '0;
      bus.cmd_params   <= '0;
      bus.cmd_overflow <= 1'b0;
      bus.seq_error    <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      state      <= state_n;
      for (int unsigned i = 0; i < NPARAM; i++) acc[i] <= acc_n[i];
      idx        <= idx_n;
      priv       <= priv_n;
      field_seen <= field_seen_n;
      ovf        <= ovf_n;
      first      <= first_n;
      tcnt       <= tcnt_n;
      bus.char_valid   <= char_valid_n;
      bus.char_data    <= char_data_n;
      bus.cmd_valid    <= cmd_valid_n;
      bus.cmd_final    <= cmd_final_n;
      bus.cmd_private  <= cmd_private_n;
      bus.cmd_nparam   <= cmd_nparam_n;
      bus.cmd_params   <= cmd_params_n;
      bus.cmd_overflow <= cmd_overflow_n;
      bus.seq_error    <= seq_error_n;
      bus.busy         <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n      = state;
    for (int unsigned i = 0; i < NPARAM; i++) acc_n[i] = acc[i];
    idx_n        = idx;
    priv_n       = priv;
    field_seen_n = field_seen;
    ovf_n        = ovf;
    first_n      = first;
    tcnt_n       = tcnt;
    char_valid_n   = 1'b0;
    cmd_valid_n    = 1'b0;
    seq_error_n    = 1'b0;
    char_data_n    = bus.char_data;
    cmd_final_n    = bus.cmd_final;
    cmd_private_n  = bus.cmd_private;
    cmd_nparam_n   = bus.cmd_nparam;
    cmd_params_n   = bus.cmd_params;
    cmd_overflow_n = bus.cmd_overflow;
    d    = bus.in_data;
    // Multiply-accumulate is widened by 4 bits so saturation is exact.
    prod = {4'b0000, acc[idx]} * TEN + {{PW{1'b0}}, d[3:0]};

    if (bus.in_valid) begin
      tcnt_n = '0;
      case (state)
        IDLE: begin
          if (d == 8'h1B) begin
            state_n = ESC;
          end else begin
            char_valid_n = 1'b1;
            char_data_n  = d;
          end
        end
        ESC: begin
          if (d == 8'h5B) begin
            state_n = CSI;
            for (int unsigned i = 0; i < NPARAM; i++) acc_n[i] = '0;
            idx_n        = '0;
            priv_n       = 1'b0;
            field_seen_n = 1'b0;
            ovf_n        = 1'b0;
            first_n      = 1'b1;
          end else if (d != 8'h1B) begin
            seq_error_n = 1'b1;
            state_n     = IDLE;
          end
        end
        CSI: begin
          first_n = 1'b0;
          if (d >= 8'h30 && d <= 8'h39) begin
            field_seen_n = 1'b1;
            if (!ovf) acc_n[idx] = (prod > SAT) ? SAT[PW-1:0] : prod[PW-1:0];
          end else if (d == 8'h3B) begin
            field_seen_n = 1'b1;
            if (idx < IDX_LAST) idx_n = idx + IW'(1);
            else                ovf_n = 1'b1;
          end else if (d == 8'h3F) begin
            if (first) begin
              priv_n = 1'b1;
            end else begin
              seq_error_n = 1'b1;
              state_n     = IDLE;
            end
          end else if (d >= 8'h40 && d <= 8'h7E) begin
            cmd_valid_n    = 1'b1;
            cmd_final_n    = d;
            cmd_private_n  = priv;
            cmd_overflow_n = ovf;
            cmd_nparam_n   = field_seen ? (NW'(idx) + NW'(1)) : '0;
            for (int unsigned i = 0; i < NPARAM; i++) cmd_params_n[i*PW +: PW] = acc[i];
            state_n = IDLE;
          end else if (d == 8'h1B) begin
            seq_error_n = 1'b1;
            state_n     = ESC;
          end else if (d == 8'h18 || d == 8'h1A) begin
            state_n = IDLE;
          end else begin
            seq_error_n = 1'b1;
            state_n     = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (tcnt == T_LAST) begin
        seq_error_n = 1'b1;
        state_n     = IDLE;
        tcnt_n      = '0;
      end else begin
        tcnt_n = tcnt + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_csi_param_parser.sv
// Table-driven bench for csi_param_parser plus timeout and mid-sequence reset cases.
module tb_csi_param_parser;
  localparam int unsigned NPARAM = 2;
  localparam int unsigned PW     = 8;

  localparam int K_NONE = 0;
  localparam int K_CHAR = 1;
  localparam int K_CMD  = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    logic [7:0]  b;
    int          kind;
    logic        busy;
    logic [7:0]  fin;
    logic [1:0]  np;
    logic [15:0] par;
    logic        priv;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  vec_t vq[$];

  csi_param_parser_if #(.NPARAM(NPARAM), .PW(PW)) bus ();

  csi_param_parser #(.NPARAM(NPARAM), .PW(PW), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic add(input logic [7:0] b, input int kind, input logic busy,
                     input logic [7:0] fin, input logic [1:0] np, input logic [15:0] par,
                     input logic priv, input logic ovf);
    vec_t v;
    v.b = b; v.kind = kind; v.busy = busy; v.fin = fin;
    v.np = np; v.par = par; v.priv = priv; v.ovf = ovf;
    vq.push_back(v);
  endtask

  task automatic pre(input logic [7:0] b);
    add(b, K_NONE, 1'b1, 8'h00, 2'd0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [3:0] pulses();
    return {bus.char_valid, bus.cmd_valid, bus.seq_error, bus.busy};
  endfunction

  initial begin
    int errs;
    logic [3:0] exp_p;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Test plan sequence 1
    pre(8'h1B); pre(8'h5B); pre(8'h31); pre(8'h32); pre(8'h3B); pre(8'h33); pre(8'h34);
    add(8'h48, K_CMD, 1'b0, 8'h48, 2'd2, 16'h220C, 1'b0, 1'b0);
    // Empty parameter list then text
    pre(8'h1B); pre(8'h5B);
    add(8'h43, K_CMD, 1'b0, 8'h43, 2'd0, 16'h0000, 1'b0, 1'b0);
    add(8'h61, K_CHAR, 1'b0, 8'h61, 2'd0, 16'h0000, 1'b0, 1'b0);
    // Saturation, then empty leading field
    pre(8'h1B); pre(8'h5B); pre(8'h39); pre(8'h39); pre(8'h39);
    add(8'h6D, K_CMD, 1'b0, 8'h6D, 2'd1, 16'h00FF, 1'b0, 1'b0);
    pre(8'h1B); pre(8'h5B); pre(8'h3B); pre(8'h35);
    add(8'h48, K_CMD, 1'b0, 8'h48, 2'd2, 16'h0500, 1'b0, 1'b0);
    // Overflow, then private prefix back-to-back after the final byte
    pre(8'h1B); pre(8'h5B); pre(8'h31); pre(8'h3B); pre(8'h32); pre(8'h3B); pre(8'h33);
    add(8'h48, K_CMD, 1'b0, 8'h48, 2'd2, 16'h0201, 1'b0, 1'b1);
    pre(8'h1B); pre(8'h5B); pre(8'h3F); pre(8'h32); pre(8'h35);
    add(8'h68, K_CMD, 1'b0, 8'h68, 2'd1, 16'h0019, 1'b1, 1'b0);
    // Errors
    pre(8'h1B);
    add(8'h78, K_ERR, 1'b0, 8'h00, 2'd0, 16'h0000, 1'b0, 1'b0);
    pre(8'h1B); pre(8'h5B); pre(8'h31);
    add(8'h3F, K_ERR, 1'b0, 8'h00, 2'd0, 16'h0000, 1'b0, 1'b0);
    pre(8'h1B); pre(8'h5B); pre(8'h31);
    add(8'h1B, K_ERR, 1'b1, 8'h00, 2'd0, 16'h0000, 1'b0, 1'b0);
    pre(8'h5B);
    add(8'h41, K_CMD, 1'b0, 8'h41, 2'd0, 16'h0000, 1'b0, 1'b0);
    pre(8'h1B); pre(8'h5B);
    add(8'h20, K_ERR, 1'b0, 8'h00, 2'd0, 16'h0000, 1'b0, 1'b0);
    // CAN aborts silently
    pre(8'h1B); pre(8'h5B); pre(8'h32);
    add(8'h18, K_NONE, 1'b0, 8'h00, 2'd0, 16'h0000, 1'b0, 1'b0);
    add(8'h41, K_CHAR, 1'b0, 8'h41, 2'd0, 16'h0000, 1'b0, 1'b0);
    // Repeated ESC, lone ';' gives two empty fields
    pre(8'h1B); pre(8'h1B); pre(8'h5B); pre(8'h3B);
    add(8'h6D, K_CMD, 1'b0, 8'h6D, 2'd2, 16'h0000, 1'b0, 1'b0);
    add(8'h0D, K_CHAR, 1'b0, 8'h0D, 2'd0, 16'h0000, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.char_valid, bus.char_data, bus.cmd_valid, bus.cmd_final,
                          bus.cmd_private, bus.cmd_nparam, bus.cmd_params,
                          bus.cmd_overflow, bus.seq_error, bus.busy}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      send(vq[i].b);
      case (vq[i].kind)
        K_CHAR:  exp_p = {1'b1, 1'b0, 1'b0, vq[i].busy};
        K_CMD:   exp_p = {1'b0, 1'b1, 1'b0, vq[i].busy};
        K_ERR:   exp_p = {1'b0, 1'b0, 1'b1, vq[i].busy};
        default: exp_p = {1'b0, 1'b0, 1'b0, vq[i].busy};
      endcase
      chk($sformatf("vec%0d_pulses", i), 64'(pulses()), 64'(exp_p));
      if (vq[i].kind == K_CHAR)
        chk($sformatf("vec%0d_char", i), 64'(bus.char_data), 64'(vq[i].fin));
      if (vq[i].kind == K_CMD)
        chk($sformatf("vec%0d_cmd", i),
            64'({bus.cmd_final, bus.cmd_nparam, bus.cmd_params, bus.cmd_private, bus.cmd_overflow}),
            64'({vq[i].fin, vq[i].np, vq[i].par, vq[i].priv, vq[i].ovf}));
    end

    // Timeout: 16 idle cycles inside a sequence abort it exactly once
    send(8'h1B); send(8'h5B); send(8'h32);
    errs = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (bus.seq_error) errs++;
    end
    chk("timeout_early", 64'({errs[7:0], bus.busy}), 64'({8'd0, 1'b1}));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.seq_error) errs++;
    end
    chk("timeout_errs", 64'(errs), 64'd1);
    chk("timeout_busy", 64'(bus.busy), 64'd0);
    send(8'h41);
    chk("timeout_then_char", 64'({bus.char_valid, bus.char_data}), 64'({1'b1, 8'h41}));

    // Reset mid-sequence overrides a concurrent valid byte
    send(8'h1B); send(8'h5B); send(8'h35);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    @(posedge clk); #1;
    chk("midreset_outputs", {bus.char_valid, bus.char_data, bus.cmd_valid, bus.cmd_final,
                             bus.cmd_private, bus.cmd_nparam, bus.cmd_params,
                             bus.cmd_overflow, bus.seq_error, bus.busy}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    send(8'h48);
    chk("midreset_then_char", 64'({bus.char_valid, bus.char_data, bus.busy}),
        64'({1'b1, 8'h48, 1'b0}));
    @(posedge clk); #1;
    chk("char_pulse_ends", 64'({pulses(), bus.char_data}), 64'({4'b0000, 8'h48}));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
